// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready handshake, flush, halt latch and forwarding tap.
// Optional macro EX_MEM_SKID_EN: DEPTH-entry skid buffer instead of a single entry.
module ex_mem_pipe #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rt_data_in,
    input  logic [31:0] inst_addr_in,
    input  logic [4:0]  rd_num_in,
    input  logic [1:0]  register_src_in,
    input  logic        register_write_in,
    input  logic        we_cache_in,
    input  logic        we_memory_in,
    input  logic        cache_input_type_in,
    input  logic        set_dirty_in,
    input  logic        set_valid_in,
    input  logic        memory_address_type_in,
    input  logic        is_word_in,
    input  logic        halted_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_result_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] inst_addr_out,
    output logic [4:0]  rd_num_out,
    output logic [1:0]  register_src_out,
    output logic        register_write_out,
    output logic        we_cache_out,
    output logic        we_memory_out,
    output logic        cache_input_type_out,
    output logic        set_dirty_out,
    output logic        set_valid_out,
    output logic        memory_address_type_out,
    output logic        is_word_out,
    output logic        halted_out,
    input  logic        flush,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        halted_seen,
    output logic [1:0]  occupancy
);

`ifdef EX_MEM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int D  = SKID ? DEPTH : 1;
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);
    localparam logic [PW-1:0] LAST = PW'(D - 1);
    localparam logic [CW-1:0] FULL = CW'(D);

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rt_data;
        logic [31:0] inst_addr;
        logic [4:0]  rd_num;
        logic [1:0]  register_src;
        logic        register_write;
        logic        we_cache;
        logic        we_memory;
        logic        cache_input_type;
        logic        set_dirty;
        logic        set_valid;
        logic        memory_address_type;
        logic        is_word;
        logic        halted;
    } entry_t;

    entry_t          mem_q [1<<PW];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            halted_q, halted_d;
    logic            push, pop;
    entry_t          in_entry, head;

    assign in_entry = '{alu_result_in, rt_data_in, inst_addr_in, rd_num_in, register_src_in,
                        register_write_in, we_cache_in, we_memory_in, cache_input_type_in,
                        set_dirty_in, set_valid_in, memory_address_type_in, is_word_in,
                        halted_in};

    assign out_valid = (count_q != '0);

`ifdef EX_MEM_SKID_EN
    // Registered-only readiness: out_ready never reaches in_ready.
    assign in_ready = !flush && !halted_q && (count_q < FULL);
`else
    assign in_ready = !flush && !halted_q && (!out_valid || out_ready);
`endif

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        halted_d = halted_q || (push && halted_in);
        if (flush) begin
            // A head consumed during flush is discarded, not counted.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Payload storage needs no reset; outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign alu_result_out          = head.alu_result;
    assign rt_data_out             = head.rt_data;
    assign inst_addr_out           = head.inst_addr;
    assign rd_num_out              = head.rd_num;
    assign register_src_out        = head.register_src;
    assign register_write_out      = head.register_write;
    assign we_cache_out            = head.we_cache;
    assign we_memory_out           = head.we_memory;
    assign cache_input_type_out    = head.cache_input_type;
    assign set_dirty_out           = head.set_dirty;
    assign set_valid_out           = head.set_valid;
    assign memory_address_type_out = head.memory_address_type;
    assign is_word_out             = head.is_word;
    assign halted_out              = head.halted;

    assign fwd_valid   = out_valid && head.register_write && (head.register_src == 2'b00)
                         && (head.rd_num != 5'd0);
    assign fwd_rd      = head.rd_num;
    assign fwd_data    = head.alu_result;
    assign halted_seen = halted_q;
    assign occupancy   = 2'(count_q);

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: vector table plus FIFO scoreboard and corner sequences.
module tb_ex_mem_pipe;

`ifdef EX_MEM_SKID_EN
    localparam bit SKID = 1'b1;
    localparam int CAP  = 2;
`else
    localparam bit SKID = 1'b0;
    localparam int CAP  = 1;
`endif

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic        rw, wec, wem, cit, sd, sv, mat, isw, halt;
    } pl_t;

    typedef struct { pl_t pl; bit fwd; } exp_t;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [1:0]  src;
        bit          rw;
        bit          iv;
        bit          ordy;
        bit          fwd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    pl_t  cur = '0;
    bit   cur_fwd = 1'b0;

    logic        in_ready, out_valid, fwd_valid, halted_seen;
    logic [31:0] alu_result_out, rt_data_out, inst_addr_out, fwd_data;
    logic [4:0]  rd_num_out, fwd_rd;
    logic [1:0]  register_src_out, occupancy;
    logic        register_write_out, we_cache_out, we_memory_out, cache_input_type_out;
    logic        set_dirty_out, set_valid_out, memory_address_type_out, is_word_out, halted_out;

    always #5 clk = ~clk;

    ex_mem_pipe #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result_in(cur.alu), .rt_data_in(cur.rt), .inst_addr_in(cur.addr),
        .rd_num_in(cur.rd), .register_src_in(cur.src), .register_write_in(cur.rw),
        .we_cache_in(cur.wec), .we_memory_in(cur.wem), .cache_input_type_in(cur.cit),
        .set_dirty_in(cur.sd), .set_valid_in(cur.sv), .memory_address_type_in(cur.mat),
        .is_word_in(cur.isw), .halted_in(cur.halt),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result_out(alu_result_out), .rt_data_out(rt_data_out),
        .inst_addr_out(inst_addr_out), .rd_num_out(rd_num_out),
        .register_src_out(register_src_out), .register_write_out(register_write_out),
        .we_cache_out(we_cache_out), .we_memory_out(we_memory_out),
        .cache_input_type_out(cache_input_type_out), .set_dirty_out(set_dirty_out),
        .set_valid_out(set_valid_out), .memory_address_type_out(memory_address_type_out),
        .is_word_out(is_word_out), .halted_out(halted_out),
        .flush(flush), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .halted_seen(halted_seen), .occupancy(occupancy)
    );

    exp_t q[$];
    bit   halted_m = 1'b0;
    int   n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic pl_t dut_head();
        return '{alu_result_out, rt_data_out, inst_addr_out, rd_num_out, register_src_out,
                 register_write_out, we_cache_out, we_memory_out, cache_input_type_out,
                 set_dirty_out, set_valid_out, memory_address_type_out, is_word_out,
                 halted_out};
    endfunction

    function automatic pl_t mk(input logic [31:0] alu, input logic [4:0] rd,
                               input logic [1:0] src, input bit rw, input bit halt);
        pl_t p;
        p      = pl_t'({$urandom, $urandom, $urandom, $urandom});
        p.alu  = alu;
        p.rd   = rd;
        p.src  = src;
        p.rw   = rw;
        p.halt = halt;
        return p;
    endfunction

    // Called at posedge+1; checks outputs before the next edge, then advances the model.
    task automatic step(input bit iv, input bit ordy, input bit fl);
        pl_t eh;
        bit  ef, eir, push, pop;
        in_valid = iv; out_ready = ordy; flush = fl;
        #2;
        eh = '0; ef = 1'b0;
        if (q.size() > 0) begin eh = q[0].pl; ef = q[0].fwd; end
        eir = !fl && !halted_m && (SKID ? (q.size() < CAP) : (q.size() == 0 || ordy));
        chk("in_ready",    in_ready,    eir);
        chk("out_valid",   out_valid,   q.size() > 0);
        chk("occupancy",   occupancy,   q.size());
        chk("halted_seen", halted_seen, halted_m);
        chk("head",        dut_head(),  eh);
        chk("fwd_valid",   fwd_valid,   ef);
        chk("fwd_rd",      fwd_rd,      eh.rd);
        chk("fwd_data",    fwd_data,    eh.alu);
        push = iv && eir;
        pop  = (q.size() > 0) && ordy;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back('{cur, cur_fwd});
                if (cur.halt) halted_m = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        vec_t tbl[10];
        tbl[0] = '{32'h0000_0010, 5'd8,  2'b00, 1, 1, 1, 1};
        tbl[1] = '{32'h0000_0020, 5'd9,  2'b01, 1, 1, 1, 0};
        tbl[2] = '{32'h0000_0030, 5'd0,  2'b00, 1, 1, 1, 0};
        tbl[3] = '{32'h0000_0040, 5'd5,  2'b00, 0, 1, 1, 0};
        tbl[4] = '{32'h0000_0050, 5'd31, 2'b10, 1, 1, 1, 0};
        tbl[5] = '{32'h0000_0060, 5'd3,  2'b00, 1, 1, 0, 1};
        tbl[6] = '{32'h0000_0070, 5'd4,  2'b00, 1, 1, 0, 1};
        tbl[7] = '{32'h0000_0080, 5'd7,  2'b00, 1, 1, 1, 1};
        tbl[8] = '{32'hDEAD_BEEF, 5'd1,  2'b00, 1, 0, 1, 1};
        tbl[9] = '{32'h0000_0090, 5'd2,  2'b00, 1, 0, 1, 1};

        // Reset values while held in reset
        #3;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst occupancy", occupancy, 2'd0);
        chk("rst halted",    halted_seen, 1'b0);
        chk("rst fwd_valid", fwd_valid, 1'b0);
        chk("rst head",      dut_head(), '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table
        foreach (tbl[i]) begin
            cur = mk(tbl[i].alu, tbl[i].rd, tbl[i].src, tbl[i].rw, 1'b0);
            cur_fwd = tbl[i].fwd;
            step(tbl[i].iv, tbl[i].ordy, 1'b0);
        end
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Stall with three entries pending, then release in order
        begin
            pl_t e[3];
            int  idx;
            for (int k = 0; k < 3; k++) e[k] = mk(32'h100 + 32'(k), 5'(10 + k), 2'b00, 1, 0);
            idx = 0;
            for (int c = 0; c < 10; c++) begin
                bit acc;
                if (idx < 3) begin cur = e[idx]; cur_fwd = 1'b1; end
                acc = (idx < 3) && !halted_m &&
                      (SKID ? (q.size() < CAP) : (q.size() == 0 || c >= 4));
                step(idx < 3, c >= 4, 1'b0);
                if (acc) idx++;
            end
            chk("stall all accepted", 32'(idx), 32'd3);
        end

        // Flush while full with input presented; accepted the cycle after
        cur = mk(32'h200, 5'd12, 2'b00, 1, 0); cur_fwd = 1'b1;
        repeat (2) step(1'b1, 1'b0, 1'b0);
        cur = mk(32'h300, 5'd13, 2'b00, 1, 0); cur_fwd = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        chk("flush empties", occupancy, 2'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("post-flush accept", alu_result_out, 32'h300);
        step(1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream with one entry held
        cur = mk(32'h400, 5'd14, 2'b00, 1, 0); cur_fwd = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", out_valid, 1'b0);
        chk("async occupancy", occupancy, 2'd0);
        chk("async head",      dut_head(), '0);
        chk("async fwd_valid", fwd_valid, 1'b0);
        q.delete(); halted_m = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);

        // Halt: intake freezes, held entry drains with halted_out=1
        cur = mk(32'h500, 5'd15, 2'b01, 1, 1); cur_fwd = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("halt latched", halted_seen, 1'b1);
        cur = mk(32'h600, 5'd16, 2'b00, 1, 0); cur_fwd = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk("halted_out", halted_out, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("halt survives flush", halted_seen, 1'b1);

        // Only reset clears halted_seen
        @(negedge clk); rst_n = 1'b0;
        q.delete(); halted_m = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("reset clears halt", halted_seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Pipeline register between the execute stage and the memory/cache stage of the five-stage MIPS core. Captures the execute-stage results (ALU result, store data, destination register, write-back and cache/memory control) under a valid/ready handshake so that a busy cache can stall the pipe without losing an instruction. Supplies the forwarding unit with the youngest ALU result, supports a synchronous flush, and freezes intake once a halting instruction has been captured.

## Interface
Parameters:
- DEPTH, 2: entries when skid buffering is compiled in; ignored (fixed at 1) otherwise.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  block accepts this cycle; a transfer occurs when in_valid && in_ready.
- alu_result_in, rt_data_in, inst_addr_in  in  32 each  execute-stage payload.
- rd_num_in  in  5  destination register number.
- register_src_in  in  2  write-back source: 00 ALU, 01 memory, 10 link.
- register_write_in, we_cache_in, we_memory_in, cache_input_type_in, set_dirty_in, set_valid_in, memory_address_type_in, is_word_in, halted_in  in  1 each  control flags.
- out_valid  out  1  head entry valid toward the memory stage.
- out_ready  in  1  memory stage consumes the head this cycle.
- *_out  out  same widths as the *_in fields  head-entry payload.
- flush  in  1  discard all held entries.
- fwd_valid  out  1  head is a forwardable ALU result.
- fwd_rd  out  5  head rd_num.
- fwd_data  out  32  head alu_result.
- halted_seen  out  1  a halting instruction has been accepted.
- occupancy  out  2  number of held entries.

## Operation
- Entries are stored in FIFO order; *_out always reflects the oldest entry, and all *_out fields are 0 when out_valid=0.
- Push on in_valid && in_ready; pop on out_valid && out_ready. A push and a pop in the same cycle leave occupancy unchanged.
- in_ready = !flush && !halted_seen && (occupancy < DEPTH, or occupancy == DEPTH with a pop this cycle when skid buffering is off).
- flush: at the next edge, clears all entries (occupancy 0, out_valid 0); no push that cycle; halted_seen is unaffected.
- Halt: accepting an entry with halted_in=1 sets halted_seen at the same edge. halted_seen stays at 1 until reset, and in_ready stays at 0. Entries already held continue to drain normally.
- fwd_valid = out_valid && register_write_out && register_src_out == 00 && rd_num_out != 0.
- Reset mid-operation: all entries are dropped immediately (asynchronous) and the outputs take their reset values.

## Timing
- Latency: an entry accepted at edge N appears on *_out at N+1 when the buffer was empty; otherwise it follows the queue.
- Throughput: one transfer per cycle when out_ready is held at 1.
- Reset values:
  - out_valid 0, all *_out 0
  - fwd_valid 0, fwd_rd 0, fwd_data 0
  - halted_seen 0, occupancy 0
  - in_ready 1 once rst_n=1 and flush=0
- Boundary conditions:
  - Full (occupancy == DEPTH): in_ready=0, input held upstream, nothing is overwritten.
  - Empty: out_valid=0, and out_ready has no effect.
  - Read/write indices wrap modulo DEPTH.
  - flush together with out_ready: the head is discarded rather than counted as consumed; the memory stage must qualify its consumption with !flush.

## Configuration
- EX_MEM_SKID_EN defined:
  - DEPTH-entry skid buffer.
  - in_ready depends only on registered state (occupancy < DEPTH, halted_seen) and flush; there is no combinational path from out_ready to in_ready.
- EX_MEM_SKID_EN undefined:
  - Single entry; occupancy is 0 or 1.
  - in_ready = !flush && !halted_seen && (!out_valid || out_ready), which is a combinational path from out_ready.

## Test plan
- Reset, then push alu_result=0x0000_0010, rd=8, register_write=1, register_src=00 with out_ready=1 -> one cycle later out_valid=1, alu_result_out=0x10, fwd_valid=1, fwd_rd=8.
- With skid, hold out_ready=0 and push 3 entries -> entries 1 and 2 accepted, in_ready=0 at occupancy=2; release out_ready -> outputs appear in order 1, 2, then entry 3 is accepted.
- Entry with register_src=01 or rd=0 -> fwd_valid=0 while out_valid=1.
- Assert flush with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, the input was not accepted; the following cycle it is accepted.
- Push an entry with halted_in=1 followed by in_valid=1 -> halted_seen=1 and in_ready=0 from the next cycle; the halted entry drains with halted_out=1; only rst_n clears halted_seen.
- Drop rst_n asynchronously mid-stream with occupancy=1 -> out_valid and all outputs go to 0 immediately, before the next clock edge.
